// File: rtl/ps2_pkg.sv
// Shared constants and byte-FSM state type for the PS/2 keyboard receiver.
package ps2_pkg;

    localparam logic [7:0]  PS2_E0         = 8'hE0;
    localparam logic [7:0]  PS2_F0         = 8'hF0;
    localparam logic [7:0]  PS2_E1         = 8'hE1;
    localparam int unsigned PS2_FRAME_BITS = 11;
    localparam int unsigned PAUSE_SKIP     = 7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } byte_state_e;

    // Device responses (error, BAT ok, echo, ack, BAT fail, resend) that are not keys.
    localparam int unsigned IGNORE_NUM  = 8;
    localparam logic [63:0] IGNORE_LIST = {8'h00, 8'hAA, 8'hEE, 8'hFA,
                                           8'hFC, 8'hFD, 8'hFE, 8'hFF};

    function automatic logic is_ignored(input logic [7:0] b);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < IGNORE_NUM; i++) begin
            if (b == IGNORE_LIST[i*8 +: 8]) hit = 1'b1;
        end
        return hit;
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line conditioning and 11-bit frame receiver: sync, clock glitch filter,
// bit counter, odd-parity/stop check and inter-edge timeout.
module ps2_frame_rx #(
    parameter int unsigned FILT           = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_dat_in,
    output logic       byte_valid_o,
    output logic [7:0] byte_o,
    output logic       frame_err_o,
    output logic       busy_o
);
    import ps2_pkg::*;

    localparam int unsigned FiltW   = (FILT > 1) ? $clog2(FILT) : 1;
    localparam int unsigned TmoW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [FiltW-1:0] FiltMax = FiltW'(FILT - 1);
    localparam logic [TmoW-1:0]  TmoLast = TmoW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]       LastBit = 4'(PS2_FRAME_BITS - 1);

    logic             clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
    logic             clk_filt_q, clk_filt_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;
    logic             fall;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic             err_q, err_d;
    logic             byte_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= ps2_clk_in;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= ps2_dat_in;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Level only flips after FILT consecutive samples disagreeing with it.
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == FiltMax) clk_filt_d = clk_s2_q;
            else                       filt_cnt_d = filt_cnt_q + 1'b1;
        end
    end

    assign fall = clk_filt_q & ~clk_filt_d;

    always_comb begin
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        tmo_d      = tmo_q;
        err_d      = 1'b0;
        byte_valid = 1'b0;
        if (fall) begin
            tmo_d = '0;
            if (bitcnt_q == 4'd0) begin
                if (!dat_s2_q) bitcnt_d = 4'd1;
            end else if (bitcnt_q <= 4'd8) begin
                shift_d  = {dat_s2_q, shift_q[7:1]};
                bitcnt_d = bitcnt_q + 4'd1;
            end else if (bitcnt_q < LastBit) begin
                par_d    = dat_s2_q;
                bitcnt_d = bitcnt_q + 4'd1;
            end else begin
                bitcnt_d = 4'd0;
                if (dat_s2_q && (^{shift_q, par_q})) byte_valid = 1'b1;
                else                                 err_d      = 1'b1;
            end
        end else if (bitcnt_q != 4'd0) begin
            if (tmo_q >= TmoLast) begin
                bitcnt_d = 4'd0;
                tmo_d    = '0;
                err_d    = 1'b1;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            clk_filt_q <= 1'b1;
            filt_cnt_q <= '0;
            bitcnt_q   <= 4'd0;
            shift_q    <= 8'h00;
            par_q      <= 1'b0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            clk_filt_q <= clk_filt_d;
            filt_cnt_q <= filt_cnt_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
        end
    end

    assign byte_valid_o = byte_valid;
    assign byte_o       = shift_q;
    assign frame_err_o  = err_q;
    assign busy_o       = (bitcnt_q != 4'd0);

endmodule

// File: rtl/ps2_key_decoder.sv
// PS/2 Set-2 keyboard decoder: turns received bytes into the toggling 11-bit
// key event word, handling E0/F0 prefixes and the E1 Pause sequence.
module ps2_key_decoder #(
    parameter int unsigned FILT           = 8,
    parameter int unsigned TIMEOUT_CYCLES = 10000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk_in,
    input  logic        ps2_dat_in,
    output logic [10:0] ps2_key,
    output logic        frame_err,
    output logic        busy
);
    import ps2_pkg::*;

    logic        rx_valid;
    logic [7:0]  rx_byte;
    logic        rx_err;
    byte_state_e state_q, state_d;
    logic [2:0]  skip_q, skip_d;
    logic [10:0] key_q, key_d;
    logic        ext, brk;

    ps2_frame_rx #(
        .FILT           (FILT),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_rx (
        .clk          (clk),
        .reset        (reset),
        .ps2_clk_in   (ps2_clk_in),
        .ps2_dat_in   (ps2_dat_in),
        .byte_valid_o (rx_valid),
        .byte_o       (rx_byte),
        .frame_err_o  (rx_err),
        .busy_o       (busy)
    );

    assign ext = (state_q == EXT) || (state_q == EXT_BRK);
    assign brk = (state_q == BRK) || (state_q == EXT_BRK);

    always_comb begin
        state_d = state_q;
        skip_d  = skip_q;
        key_d   = key_q;
        if (rx_err) begin
            state_d = IDLE;
            skip_d  = 3'd0;
        end else if (rx_valid) begin
            if (state_q == SKIP) begin
                skip_d = skip_q - 3'd1;
                if (skip_q == 3'd1) state_d = IDLE;
            end else if (rx_byte == PS2_E1) begin
                state_d = SKIP;
                skip_d  = 3'(PAUSE_SKIP);
            end else if (rx_byte == PS2_E0) begin
                state_d = brk ? EXT_BRK : EXT;
            end else if (rx_byte == PS2_F0) begin
                state_d = ext ? EXT_BRK : BRK;
            end else if (!((state_q == IDLE) && is_ignored(rx_byte))) begin
                key_d   = {~key_q[10], ~brk, ext, rx_byte};
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            skip_q  <= 3'd0;
            key_q   <= 11'h000;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            key_q   <= key_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = rx_err;

endmodule
